// File: rtl/multiplier_if.sv
// Operand/result bundle for the sequential Booth multiplier.
// op_m is the multiplicand (M), op_q the multiplier operand (Q).
`timescale 1ns/1ps
interface multiplier_if #(
    parameter int WORD_LENGTH = 16
);
    logic [WORD_LENGTH-1:0] op_m;
    logic [WORD_LENGTH-1:0] op_q;
    logic [WORD_LENGTH-1:0] result;

    // Producer of operands / consumer of the product.
    modport master (
        output op_m,
        output op_q,
        input  result
    );

    // The multiplier itself.
    modport slave (
        input  op_m,
        input  op_q,
        output result
    );
endinterface

// File: rtl/multiplier.sv
// Free-running sequential signed radix-2 Booth multiplier.
// Loops LOAD -> ITERATE (WORD_LENGTH cycles) -> DONE and publishes the low
// WORD_LENGTH bits of op_m * op_q on a registered output once per period.
`timescale 1ns/1ps
module multiplier #(
    parameter int WORD_LENGTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    multiplier_if.slave  bus_if
);
    localparam int CNT_W = $clog2(WORD_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_ITERATE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [WORD_LENGTH-1:0] a_q, a_d;
    logic [WORD_LENGTH-1:0] q_q, q_d;
    logic                   q1_q, q1_d;
    logic [WORD_LENGTH-1:0] m_q, m_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_LENGTH-1:0] result_q, result_d;
    logic [WORD_LENGTH-1:0] sum;

    // State register; reset forces a fresh LOAD.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed-length loop, leaves ITERATE after the last step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:    state_d = S_ITERATE;
            S_ITERATE: if (cnt_q == LAST_ITER) state_d = S_DONE;
            S_DONE:    state_d = S_LOAD;
            default:   state_d = S_LOAD;
        endcase
    end

    // Booth recoding of {Q[0], Q_1}: add M, subtract M, or pass A (wraps).
    always_comb begin
        case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
    end

    // Datapath/output next-state: load operands, shift {A,Q,Q_1}, publish Q.
    always_comb begin
        a_d      = a_q;
        q_d      = q_q;
        q1_d     = q1_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_LOAD: begin
                a_d   = '0;
                q_d   = bus_if.op_q;
                q1_d  = 1'b0;
                m_d   = bus_if.op_m;
                cnt_d = '0;
            end
            S_ITERATE: begin
                // Arithmetic shift right using the sign of the post-add A.
                a_d   = {sum[WORD_LENGTH-1], sum[WORD_LENGTH-1:1]};
                q_d   = {sum[0], q_q[WORD_LENGTH-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                // Q now holds the low half of the full product {A,Q}.
                result_d = q_q;
            end
            default: ;
        endcase
    end

    // Datapath and result registers; reset abandons any computation.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_q      <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            a_q      <= a_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus_if.result = result_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the free-running Booth multiplier.
`timescale 1ns/1ps
module tb_multiplier;
    localparam int W = 16;
    localparam int P = W + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    multiplier_if #(.WORD_LENGTH(W)) bus ();

    multiplier #(.WORD_LENGTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (bus)
    );

    // Reference: signed product by plain arithmetic, truncated to W bits.
    function automatic logic [W-1:0] ref_prod(input logic [W-1:0] m, input logic [W-1:0] q);
        longint p;
        p = longint'($signed(m)) * longint'($signed(q));
        return p[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1ns so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Hold reset for one edge with operands applied, release; next edge is edge 1 (LOAD).
    task automatic start(input logic [W-1:0] m, input logic [W-1:0] q);
        rst_n    = 1'b0;
        bus.op_m = m;
        bus.op_q = q;
        step();
        rst_n = 1'b1;
    endtask

    logic [W-1:0] tab_m [4];
    logic [W-1:0] tab_q [4];
    logic [W-1:0] tab_r [4];

    initial begin
        logic [W-1:0] lat_m, lat_q, exp_cur;

        tab_m[0] = 16'hFFFF; tab_q[0] = 16'hFFFF; tab_r[0] = 16'h0001;
        tab_m[1] = 16'h0000; tab_q[1] = 16'h7FFF; tab_r[1] = 16'h0000;
        tab_m[2] = 16'h00FF; tab_q[2] = 16'h00FF; tab_r[2] = 16'hFE01;
        tab_m[3] = 16'h8000; tab_q[3] = 16'hFFFF; tab_r[3] = 16'h8000;

        // Reset state
        bus.op_m = 16'h1234;
        bus.op_q = 16'h5678;
        rst_n    = 1'b0;
        steps(3);
        check("reset", bus.result, '0);
        $display("txn reset: result=%h", bus.result);

        // 60 x -2, held from reset release
        start(16'd60, 16'hFFFE);
        steps(17);
        check("60x-2_e17", bus.result, '0);
        step();
        check("60x-2_e18", bus.result, 16'hFF88);
        check("60x-2_ref", bus.result, ref_prod(16'd60, 16'hFFFE));
        steps(18);
        check("60x-2_e36", bus.result, 16'hFF88);
        $display("txn 60*-2: result=%h", bus.result);

        // Directed corner products
        for (int i = 0; i < 4; i++) begin
            start(tab_m[i], tab_q[i]);
            steps(P);
            check("corner", bus.result, tab_r[i]);
            check("corner_ref", bus.result, ref_prod(tab_m[i], tab_q[i]));
            $display("txn %h*%h: result=%h", tab_m[i], tab_q[i], bus.result);
        end

        // Operand change mid-ITERATE is ignored until the next LOAD
        start(16'd3, 16'd5);
        steps(9);
        bus.op_m = 16'd7;
        bus.op_q = 16'd9;
        steps(9);
        check("midchg_e18", bus.result, 16'd15);
        steps(18);
        check("midchg_e36", bus.result, 16'd63);
        $display("txn 3*5->7*9: result=%h", bus.result);

        // Reset mid-ITERATE clears Result and restarts the computation
        start(16'd3, 16'd5);
        steps(P);
        check("rst_prior", bus.result, 16'd15);
        steps(9);
        rst_n    = 1'b0;
        bus.op_m = 16'd11;
        bus.op_q = 16'd13;
        step();
        check("rst_clear", bus.result, '0);
        rst_n = 1'b1;
        step();                      // LOAD
        steps(16);
        check("rst_pre_done", bus.result, '0);
        step();                      // DONE, 17 edges after LOAD
        check("rst_restart", bus.result, 16'd143);
        $display("txn reset-restart 11*13: result=%h", bus.result);

        // Free-running random operands, changed at arbitrary edges
        start(16'($urandom), 16'($urandom));
        exp_cur = '0;
        lat_m   = '0;
        lat_q   = '0;
        for (int e = 1; e <= 12 * P; e++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 5))
                    0:       bus.op_m = 16'h8000;
                    1:       bus.op_m = 16'h7FFF;
                    default: bus.op_m = 16'($urandom);
                endcase
                bus.op_q = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
            end
            if (e % P == 1) begin
                lat_m = bus.op_m;
                lat_q = bus.op_q;
            end
            step();
            if (e % P == 0) begin
                exp_cur = ref_prod(lat_m, lat_q);
                $display("txn rand %h*%h: result=%h expected=%h", lat_m, lat_q, bus.result, exp_cur);
            end
            check("free_run", bus.result, exp_cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
